// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver: latches a binary value, converts it
// to BCD by shift-add-3, then scans digits with blanking, blink and overflow.
module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int VAL_W      = 14,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_FR   = 64,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [VAL_W-1:0]  DATA_IN,
    input  logic              LOAD,
    input  logic              BLINK,
    output logic              BUSY,
    output logic              OVF,
    output logic [6:0]        SEG,
    output logic [DIGITS-1:0] DIGIT_EN
);

    localparam int BW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam int CW = $clog2(VAL_W);
    localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);
    localparam logic [3:0]  DASH  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t            state;
    logic [VAL_W-1:0]  sh;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_nx;
    logic [BW-1:0]     disp;
    logic [CW-1:0]     step;
    logic              over;

    // One double-dabble step: correct nibbles, then shift in the binary MSB.
    always_comb begin
        bcd_nx = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_nx[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_nx = {bcd_nx[BW-2:0], sh[VAL_W-1]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sh    <= '0;
            bcd   <= '0;
            step  <= '0;
            over  <= 1'b0;
            disp  <= '0;
            BUSY  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (LOAD) begin
                        sh    <= DATA_IN;
                        bcd   <= '0;
                        step  <= '0;
                        over  <= (64'(DATA_IN) >= LIMIT);
                        BUSY  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_nx;
                    sh   <= {sh[VAL_W-2:0], 1'b0};
                    step <= step + 1'b1;
                    if (step == CW'(VAL_W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (over) begin
                        disp <= {DIGITS{DASH}};
                        OVF  <= 1'b1;
                    end else begin
                        disp <= bcd;
                        OVF  <= 1'b0;
                    end
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [SW-1:0] scnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic          phase;
    logic          wrap;
    logic          last;

    assign wrap = (scnt == SW'(SCAN_DIV - 1));
    assign last = (idx == IW'(DIGITS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            scnt  <= '0;
            idx   <= '0;
            fcnt  <= '0;
            phase <= 1'b0;
        end else begin
            scnt <= wrap ? '0 : scnt + 1'b1;
            if (wrap) begin
                idx <= last ? '0 : idx + 1'b1;
                // Frame boundary: advance or restart the blink cadence.
                if (last) begin
                    if (!BLINK) begin
                        fcnt  <= '0;
                        phase <= 1'b0;
                    end else if (fcnt == FW'(BLINK_FR - 1)) begin
                        fcnt  <= '0;
                        phase <= ~phase;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h67;
            DASH:    glyph = 7'h40;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [3:0]        nib;
    logic [DIGITS-1:0] zero_up;
    logic              lz;
    logic [6:0]        seg_nx;
    logic [DIGITS-1:0] en_nx;

    // zero_up[i]: digit i and every digit above it are zero.
    always_comb begin
        nib     = '0;
        lz      = 1'b0;
        en_nx   = '0;
        zero_up = '0;
        zero_up[DIGITS-1] = (disp[BW-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_up[i] = zero_up[i+1] && (disp[4*i +: 4] == 4'd0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib      = disp[4*i +: 4];
                en_nx[i] = 1'b1;
                lz       = (i > 0) && zero_up[i];
            end
        end
        seg_nx = glyph(nib);
        if ((BLINK && phase) || (BLANK_LZ && !OVF && lz)) begin
            seg_nx = 7'h00;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG      <= {7{ACTIVE_LOW}};
            DIGIT_EN <= {DIGITS{ACTIVE_LOW}};
        end else begin
            SEG      <= seg_nx ^ {7{ACTIVE_LOW}};
            DIGIT_EN <= en_nx ^ {DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver; expected output from a decimal-arithmetic
// model of the display timed against the cycle count since reset.
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 4;
    localparam int BLINK_FR = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [VAL_W-1:0] DATA_IN = '0;
    logic             LOAD = 1'b0;
    logic             BLINK = 1'b0;

    logic busy, ovf, busy_n, ovf_n, busy_a, ovf_a;
    logic [6:0] seg, seg_n, seg_a;
    logic [DIGITS-1:0] en, en_n, en_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit blink_on = 1'b0;

    seg_scan_driver #(
        .DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV),
        .BLINK_FR(BLINK_FR), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD(LOAD), .BLINK(BLINK),
        .BUSY(busy), .OVF(ovf), .SEG(seg), .DIGIT_EN(en)
    );

    seg_scan_driver #(
        .DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV),
        .BLINK_FR(BLINK_FR), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)
    ) dut_nlz (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD(LOAD), .BLINK(BLINK),
        .BUSY(busy_n), .OVF(ovf_n), .SEG(seg_n), .DIGIT_EN(en_n)
    );

    seg_scan_driver #(
        .DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV),
        .BLINK_FR(BLINK_FR), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
    ) dut_al (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD(LOAD), .BLINK(BLINK),
        .BUSY(busy_a), .OVF(ovf_a), .SEG(seg_a), .DIGIT_EN(en_a)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h67;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k,
                                           input bit lzb, input bit blanked);
        if (blanked) return 7'h00;
        if (v >= pow10(DIGITS)) return 7'h40;
        if (lzb && k > 0 && v < pow10(k)) return 7'h00;
        return glyph((v / pow10(k)) % 10);
    endfunction

    task automatic do_reset(input bit blink);
        RST = 1'b1;
        LOAD = 1'b0;
        BLINK = blink;
        blink_on = blink;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic load_val(input int v);
        @(posedge CLK);
        #1;
        DATA_IN = VAL_W'(v);
        LOAD = 1'b1;
        @(posedge CLK);
        #1;
        LOAD = 1'b0;
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        while (busy && nb < 64) begin
            nb++;
            @(posedge CLK);
            #1;
        end
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout actual %b required 0", busy);
        end
    endtask

    task automatic check_frame(input int v, input int n, input string tag);
        int idx, f;
        bit bl;
        logic [6:0] es, en_s;
        logic [DIGITS-1:0] ee;
        bit eo;
        eo = (v >= pow10(DIGITS));
        checks++;
        if (ovf !== eo || ovf_n !== eo || ovf_a !== eo) begin
            errors++;
            $display("FAIL %s ovf actual %b%b%b required %b", tag,
                     ovf, ovf_n, ovf_a, eo);
        end
        for (int s = 0; s < n; s++) begin
            @(posedge CLK);
            #1;
            idx = ((cyc - 1) / SCAN_DIV) % DIGITS;
            f = (cyc - 1) / (SCAN_DIV * DIGITS);
            bl = blink_on && ((f / BLINK_FR) % 2 == 1);
            ee = DIGITS'(1 << idx);
            es = exp_seg(v, idx, 1'b1, bl);
            en_s = exp_seg(v, idx, 1'b0, bl);
            checks++;
            if (seg !== es || en !== ee) begin
                errors++;
                $display("FAIL %s lz cyc %0d actual %h/%b required %h/%b",
                         tag, cyc, seg, en, es, ee);
            end
            checks++;
            if (seg_n !== en_s || en_n !== ee) begin
                errors++;
                $display("FAIL %s nolz cyc %0d actual %h/%b required %h/%b",
                         tag, cyc, seg_n, en_n, en_s, ee);
            end
            checks++;
            if (seg_a !== ~es || en_a !== ~ee) begin
                errors++;
                $display("FAIL %s actlow cyc %0d actual %h/%b required %h/%b",
                         tag, cyc, seg_a, en_a, ~es, ~ee);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        BLINK = 1'b0;
        blink_on = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0 || seg !== 7'h00 || en !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs actual %b %b %h %b required 0 0 00 0000",
                     busy, ovf, seg, en);
        end
        checks++;
        if (seg_a !== 7'h7F || en_a !== 4'hF) begin
            errors++;
            $display("FAIL reset_actlow actual %h %b required 7f 1111", seg_a, en_a);
        end
        RST = 1'b0;
        check_frame(0, 2 * SCAN_DIV * DIGITS, "reset_frame");
    endtask

    task automatic test_basic();
        int nb;
        do_reset(1'b0);
        load_val(1234);
        wait_idle(nb);
        checks++;
        if (nb != VAL_W + 1) begin
            errors++;
            $display("FAIL busy_len actual %0d required %0d", nb, VAL_W + 1);
        end
        check_frame(1234, 2 * SCAN_DIV * DIGITS, "v1234");
    endtask

    task automatic test_lz_ovf();
        int nb;
        int vals[5] = '{7, 10000, 9999, 16383, 0};
        foreach (vals[i]) begin
            load_val(vals[i]);
            wait_idle(nb);
            check_frame(vals[i], SCAN_DIV * DIGITS, "lz_ovf");
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        load_val(42);
        repeat (2) @(posedge CLK);
        #1;
        DATA_IN = VAL_W'(99);
        LOAD = 1'b1;
        @(posedge CLK);
        #1;
        LOAD = 1'b0;
        wait_idle(nb);
        check_frame(42, SCAN_DIV * DIGITS, "drop");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_queued actual %b required 0", busy);
        end
    endtask

    task automatic test_abort();
        load_val(555);
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy actual %b required 0", busy);
        end
        RST = 1'b0;
        check_frame(0, SCAN_DIV * DIGITS, "abort");
    endtask

    task automatic test_random();
        int nb, v;
        for (int i = 0; i < 12; i++) begin
            v = (i % 3 == 0) ? int'($urandom_range(0, 120))
                             : int'($urandom_range(0, 16383));
            load_val(v);
            wait_idle(nb);
            checks++;
            if (nb != VAL_W + 1) begin
                errors++;
                $display("FAIL rand_busy actual %0d required %0d", nb, VAL_W + 1);
            end
            check_frame(v, SCAN_DIV * DIGITS, "random");
        end
    endtask

    task automatic test_blink();
        int nb;
        do_reset(1'b1);
        load_val(88);
        wait_idle(nb);
        check_frame(88, 6 * SCAN_DIV * DIGITS, "blink");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz_ovf();
        test_back_to_back();
        test_abort();
        test_random();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
